// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the hazard controller: widths, forwarding encodings,
// PC register number and FSM state encoding.
package hazard_unit_pkg;

  localparam int unsigned REG_W   = 4;
  localparam int unsigned CNT_W   = 8;
  localparam int unsigned FWD_W   = 2;
  localparam int unsigned STATS_W = 16;

  localparam logic [REG_W-1:0] PC_REG = 4'd15;

  localparam logic [FWD_W-1:0] FWD_RF  = 2'b00;
  localparam logic [FWD_W-1:0] FWD_EX  = 2'b01;
  localparam logic [FWD_W-1:0] FWD_MEM = 2'b10;
  localparam logic [FWD_W-1:0] FWD_WB  = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2
  } hz_state_e;

  // A read source matches a producer that really writes a GPR (never the PC).
  function automatic logic reg_hit(input logic use_src, input logic [REG_W-1:0] src,
                                   input logic wr_en, input logic [REG_W-1:0] dst);
    return use_src & wr_en & (dst != PC_REG) & (src == dst);
  endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline <-> hazard controller signal bundle. HAZARD_STATS_EN adds stall_count.
interface hazard_unit_if;
  import hazard_unit_pkg::*;

  logic [REG_W-1:0] id_rn, id_rm, id_rd;
  logic             id_use_rn, id_use_rm, id_use_rd;
  logic [REG_W-1:0] ex_rd;
  logic             ex_rf_en, ex_load;
  logic [REG_W-1:0] mem_rd;
  logic             mem_rf_en;
  logic [REG_W-1:0] wb_rd;
  logic             wb_rf_en;
  logic             mem_access, mem_ready;
  logic             ex_branch_taken;

  logic             cu_sel, pc_le, ifid_le, ifid_flush, pipe_hold, mem_fault;
  logic [FWD_W-1:0] fwd_a, fwd_b, fwd_c;
`ifdef HAZARD_STATS_EN
  logic [STATS_W-1:0] stall_count;
`endif

  modport master (
`ifdef HAZARD_STATS_EN
    input  stall_count,
`endif
    output id_rn, id_rm, id_rd, id_use_rn, id_use_rm, id_use_rd,
    output ex_rd, ex_rf_en, ex_load, mem_rd, mem_rf_en, wb_rd, wb_rf_en,
    output mem_access, mem_ready, ex_branch_taken,
    input  cu_sel, pc_le, ifid_le, ifid_flush, pipe_hold, mem_fault,
    input  fwd_a, fwd_b, fwd_c
  );

  modport slave (
`ifdef HAZARD_STATS_EN
    output stall_count,
`endif
    input  id_rn, id_rm, id_rd, id_use_rn, id_use_rm, id_use_rd,
    input  ex_rd, ex_rf_en, ex_load, mem_rd, mem_rf_en, wb_rd, wb_rf_en,
    input  mem_access, mem_ready, ex_branch_taken,
    output cu_sel, pc_le, ifid_le, ifid_flush, pipe_hold, mem_fault,
    output fwd_a, fwd_b, fwd_c
  );

endinterface

// File: rtl/hazard_fwd_sel.sv
// Per-operand forwarding selector: EX (non-load) beats MEM beats WB, else regfile.
module hazard_fwd_sel
  import hazard_unit_pkg::*;
(
  input  logic             i_use,
  input  logic [REG_W-1:0] i_src,
  input  logic [REG_W-1:0] i_ex_rd,
  input  logic             i_ex_en,
  input  logic [REG_W-1:0] i_mem_rd,
  input  logic             i_mem_en,
  input  logic [REG_W-1:0] i_wb_rd,
  input  logic             i_wb_en,
  output logic [FWD_W-1:0] o_sel
);

  always_comb begin
    o_sel = FWD_RF;
    if (reg_hit(i_use, i_src, i_ex_en, i_ex_rd))        o_sel = FWD_EX;
    else if (reg_hit(i_use, i_src, i_mem_en, i_mem_rd)) o_sel = FWD_MEM;
    else if (reg_hit(i_use, i_src, i_wb_en, i_wb_rd))   o_sel = FWD_WB;
  end

endmodule

// File: rtl/hazard_unit.sv
// 5-stage pipeline hazard controller: load-use bubbles, memory-wait freeze with
// timeout, branch flush and operand forwarding. HAZARD_STATS_EN adds stall_count.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int unsigned LU_STALL_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT     = 15
) (
  input  logic         clk,
  input  logic         reset,
  hazard_unit_if.slave io_bus
);

  hz_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_wait_cnt;
  logic             w_mem_wait, w_lu_hit;
  logic             w_cu_sel, w_pc_le, w_ifid_le, w_ifid_flush, w_pipe_hold, w_mem_fault;
  logic [FWD_W-1:0] w_fwd_a, w_fwd_b, w_fwd_c;

  assign w_mem_wait = io_bus.mem_access & ~io_bus.mem_ready;
  assign w_wait_cnt = (r_state == ST_MEM_WAIT) ? r_cnt : '0;
  assign w_lu_hit   = io_bus.ex_load &
                      (reg_hit(io_bus.id_use_rn, io_bus.id_rn, io_bus.ex_rf_en, io_bus.ex_rd) |
                       reg_hit(io_bus.id_use_rm, io_bus.id_rm, io_bus.ex_rf_en, io_bus.ex_rd) |
                       reg_hit(io_bus.id_use_rd, io_bus.id_rd, io_bus.ex_rf_en, io_bus.ex_rd));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Next state and hazard outputs; priority is memory wait > branch > load-use.
  always_comb begin
    w_state_nxt  = ST_RUN;
    w_cnt_nxt    = '0;
    w_cu_sel     = 1'b0;
    w_pc_le      = 1'b1;
    w_ifid_le    = 1'b1;
    w_ifid_flush = 1'b0;
    w_pipe_hold  = 1'b0;
    w_mem_fault  = 1'b0;
    if (reset) begin
      w_state_nxt = ST_RUN;
    end else if (w_mem_wait) begin
      if (w_wait_cnt == CNT_W'(MEM_TIMEOUT - 1)) begin
        w_mem_fault = 1'b1;
      end else begin
        w_pipe_hold = 1'b1;
        w_pc_le     = 1'b0;
        w_ifid_le   = 1'b0;
        w_state_nxt = ST_MEM_WAIT;
        w_cnt_nxt   = w_wait_cnt + 8'd1;
      end
    end else if (io_bus.ex_branch_taken) begin
      w_ifid_flush = 1'b1;
      w_cu_sel     = 1'b1;
    end else if (r_state == ST_LU_STALL) begin
      w_cu_sel  = 1'b1;
      w_pc_le   = 1'b0;
      w_ifid_le = 1'b0;
      if (r_cnt > 8'd1) begin
        w_state_nxt = ST_LU_STALL;
        w_cnt_nxt   = r_cnt - 8'd1;
      end
    end else if (w_lu_hit) begin
      w_cu_sel  = 1'b1;
      w_pc_le   = 1'b0;
      w_ifid_le = 1'b0;
      if (LU_STALL_CYCLES > 1) begin
        w_state_nxt = ST_LU_STALL;
        w_cnt_nxt   = CNT_W'(LU_STALL_CYCLES - 1);
      end
    end
  end

  hazard_fwd_sel u_fwd_a (
    .i_use(io_bus.id_use_rn), .i_src(io_bus.id_rn),
    .i_ex_rd(io_bus.ex_rd), .i_ex_en(io_bus.ex_rf_en & ~io_bus.ex_load),
    .i_mem_rd(io_bus.mem_rd), .i_mem_en(io_bus.mem_rf_en),
    .i_wb_rd(io_bus.wb_rd), .i_wb_en(io_bus.wb_rf_en), .o_sel(w_fwd_a)
  );

  hazard_fwd_sel u_fwd_b (
    .i_use(io_bus.id_use_rm), .i_src(io_bus.id_rm),
    .i_ex_rd(io_bus.ex_rd), .i_ex_en(io_bus.ex_rf_en & ~io_bus.ex_load),
    .i_mem_rd(io_bus.mem_rd), .i_mem_en(io_bus.mem_rf_en),
    .i_wb_rd(io_bus.wb_rd), .i_wb_en(io_bus.wb_rf_en), .o_sel(w_fwd_b)
  );

  hazard_fwd_sel u_fwd_c (
    .i_use(io_bus.id_use_rd), .i_src(io_bus.id_rd),
    .i_ex_rd(io_bus.ex_rd), .i_ex_en(io_bus.ex_rf_en & ~io_bus.ex_load),
    .i_mem_rd(io_bus.mem_rd), .i_mem_en(io_bus.mem_rf_en),
    .i_wb_rd(io_bus.wb_rd), .i_wb_en(io_bus.wb_rf_en), .o_sel(w_fwd_c)
  );

  assign io_bus.cu_sel     = w_cu_sel;
  assign io_bus.pc_le      = w_pc_le;
  assign io_bus.ifid_le    = w_ifid_le;
  assign io_bus.ifid_flush = w_ifid_flush;
  assign io_bus.pipe_hold  = w_pipe_hold;
  assign io_bus.mem_fault  = w_mem_fault;
  assign io_bus.fwd_a      = reset ? FWD_RF : w_fwd_a;
  assign io_bus.fwd_b      = reset ? FWD_RF : w_fwd_b;
  assign io_bus.fwd_c      = reset ? FWD_RF : w_fwd_c;

`ifdef HAZARD_STATS_EN
  logic [STATS_W-1:0] r_stall_count;

  // Saturating count of cycles spent bubbling or frozen.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_count <= '0;
    end else if ((w_cu_sel | w_pipe_hold) && (r_stall_count != '1)) begin
      r_stall_count <= r_stall_count + 16'd1;
    end
  end

  assign io_bus.stall_count = reset ? '0 : r_stall_count;
`endif

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: dut_a (1 bubble, timeout 4) and dut_b
// (3 bubbles, timeout 15) see identical pipeline stimulus.
module tb_hazard_unit;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_miss;

  hazard_unit_if bus_a ();
  hazard_unit_if bus_b ();

  hazard_unit #(.LU_STALL_CYCLES(1), .MEM_TIMEOUT(4))  dut_a (.clk(clk), .reset(reset), .io_bus(bus_a));
  hazard_unit #(.LU_STALL_CYCLES(3), .MEM_TIMEOUT(15)) dut_b (.clk(clk), .reset(reset), .io_bus(bus_b));

  assign bus_b.id_rn = bus_a.id_rn;         assign bus_b.id_rm = bus_a.id_rm;
  assign bus_b.id_rd = bus_a.id_rd;         assign bus_b.id_use_rn = bus_a.id_use_rn;
  assign bus_b.id_use_rm = bus_a.id_use_rm; assign bus_b.id_use_rd = bus_a.id_use_rd;
  assign bus_b.ex_rd = bus_a.ex_rd;         assign bus_b.ex_rf_en = bus_a.ex_rf_en;
  assign bus_b.ex_load = bus_a.ex_load;     assign bus_b.mem_rd = bus_a.mem_rd;
  assign bus_b.mem_rf_en = bus_a.mem_rf_en; assign bus_b.wb_rd = bus_a.wb_rd;
  assign bus_b.wb_rf_en = bus_a.wb_rf_en;   assign bus_b.mem_access = bus_a.mem_access;
  assign bus_b.mem_ready = bus_a.mem_ready; assign bus_b.ex_branch_taken = bus_a.ex_branch_taken;

  // {cu_sel, pc_le, ifid_le, ifid_flush, pipe_hold, mem_fault}
  logic [5:0] ctl_a, ctl_b;
  assign ctl_a = {bus_a.cu_sel, bus_a.pc_le, bus_a.ifid_le, bus_a.ifid_flush, bus_a.pipe_hold, bus_a.mem_fault};
  assign ctl_b = {bus_b.cu_sel, bus_b.pc_le, bus_b.ifid_le, bus_b.ifid_flush, bus_b.pipe_hold, bus_b.mem_fault};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    bus_a.id_rn = 4'd0; bus_a.id_rm = 4'd0; bus_a.id_rd = 4'd0;
    bus_a.id_use_rn = 1'b0; bus_a.id_use_rm = 1'b0; bus_a.id_use_rd = 1'b0;
    bus_a.ex_rd = 4'd0; bus_a.ex_rf_en = 1'b0; bus_a.ex_load = 1'b0;
    bus_a.mem_rd = 4'd0; bus_a.mem_rf_en = 1'b0;
    bus_a.wb_rd = 4'd0; bus_a.wb_rf_en = 1'b0;
    bus_a.mem_access = 1'b0; bus_a.mem_ready = 1'b0; bus_a.ex_branch_taken = 1'b0;
  endtask

  // Advance to just after the next rising edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      cyc();
      idle();
    end
  endtask

  task automatic test_reset();
    cyc();
    reset = 1'b1;
    idle();
    bus_a.ex_load = 1'b1; bus_a.ex_rf_en = 1'b1; bus_a.ex_rd = 4'd1;
    bus_a.id_rn = 4'd1; bus_a.id_use_rn = 1'b1;
    bus_a.mem_rd = 4'd1; bus_a.mem_rf_en = 1'b1;
    bus_a.mem_access = 1'b1; bus_a.ex_branch_taken = 1'b1;
    #2;
    n_vec++; if (ctl_a !== 6'b011000) begin $display("FAIL reset_ctl_a got %b exp 011000", ctl_a); n_miss++; end
    n_vec++; if (ctl_b !== 6'b011000) begin $display("FAIL reset_ctl_b got %b exp 011000", ctl_b); n_miss++; end
    n_vec++; if (bus_a.fwd_a !== 2'b00) begin $display("FAIL reset_fwd_a got %b exp 00", bus_a.fwd_a); n_miss++; end
`ifdef HAZARD_STATS_EN
    n_vec++; if (bus_a.stall_count !== 16'd0) begin $display("FAIL reset_stats got %0d exp 0", bus_a.stall_count); n_miss++; end
`endif
    cyc();
    reset = 1'b0;
    idle();
  endtask

  task automatic test_load_use();
    cyc();
    idle();
    bus_a.ex_load = 1'b1; bus_a.ex_rf_en = 1'b1; bus_a.ex_rd = 4'd1;
    bus_a.id_rn = 4'd1; bus_a.id_use_rn = 1'b1;
    #2;
    n_vec++; if (ctl_a !== 6'b100000) begin $display("FAIL lu_detect_a got %b exp 100000", ctl_a); n_miss++; end
    n_vec++; if (ctl_b !== 6'b100000) begin $display("FAIL lu_detect_b got %b exp 100000", ctl_b); n_miss++; end
    n_vec++; if (bus_a.fwd_a !== 2'b00) begin $display("FAIL lu_nofwd_load got %b exp 00", bus_a.fwd_a); n_miss++; end
    cyc();
    bus_a.ex_load = 1'b0; bus_a.ex_rf_en = 1'b0; bus_a.ex_rd = 4'd0;
    bus_a.mem_rd = 4'd1; bus_a.mem_rf_en = 1'b1;
    #2;
    n_vec++; if (ctl_a !== 6'b011000) begin $display("FAIL lu_release_a got %b exp 011000", ctl_a); n_miss++; end
    n_vec++; if (bus_a.fwd_a !== 2'b10) begin $display("FAIL lu_fwd_mem got %b exp 10", bus_a.fwd_a); n_miss++; end
    n_vec++; if (ctl_b !== 6'b100000) begin $display("FAIL lu_stall2_b got %b exp 100000", ctl_b); n_miss++; end
    cyc();
    #2;
    n_vec++; if (ctl_b !== 6'b100000) begin $display("FAIL lu_stall3_b got %b exp 100000", ctl_b); n_miss++; end
    cyc();
    #2;
    n_vec++; if (ctl_b !== 6'b011000) begin $display("FAIL lu_release_b got %b exp 011000", ctl_b); n_miss++; end
    idle_cycles(1);
  endtask

  task automatic test_forwarding();
    cyc();
    idle();
    bus_a.ex_rd = 4'd2; bus_a.ex_rf_en = 1'b1; bus_a.wb_rd = 4'd2; bus_a.wb_rf_en = 1'b1;
    bus_a.id_rm = 4'd2; bus_a.id_use_rm = 1'b1;
    #2;
    n_vec++; if (bus_a.fwd_b !== 2'b01) begin $display("FAIL fwd_ex_over_wb got %b exp 01", bus_a.fwd_b); n_miss++; end
    n_vec++; if (ctl_a !== 6'b011000) begin $display("FAIL fwd_no_stall got %b exp 011000", ctl_a); n_miss++; end
    cyc();
    bus_a.ex_rd = 4'd15; bus_a.wb_rd = 4'd15; bus_a.id_rm = 4'd15;
    #2;
    n_vec++; if (bus_a.fwd_b !== 2'b00) begin $display("FAIL fwd_pc_reg got %b exp 00", bus_a.fwd_b); n_miss++; end
    cyc();
    bus_a.ex_rd = 4'd2; bus_a.wb_rd = 4'd2; bus_a.id_rm = 4'd2; bus_a.id_use_rm = 1'b0;
    #2;
    n_vec++; if (bus_a.fwd_b !== 2'b00) begin $display("FAIL fwd_unused got %b exp 00", bus_a.fwd_b); n_miss++; end
    cyc();
    bus_a.id_use_rm = 1'b1; bus_a.ex_rf_en = 1'b0; bus_a.mem_rd = 4'd2; bus_a.mem_rf_en = 1'b1;
    #2;
    n_vec++; if (bus_a.fwd_b !== 2'b10) begin $display("FAIL fwd_mem_over_wb got %b exp 10", bus_a.fwd_b); n_miss++; end
    cyc();
    bus_a.mem_rf_en = 1'b0;
    #2;
    n_vec++; if (bus_a.fwd_b !== 2'b11) begin $display("FAIL fwd_wb got %b exp 11", bus_a.fwd_b); n_miss++; end
    cyc();
    idle();
    bus_a.id_rd = 4'd5; bus_a.id_use_rd = 1'b1;
    bus_a.ex_rd = 4'd5; bus_a.ex_rf_en = 1'b1; bus_a.ex_load = 1'b1;
    bus_a.mem_rd = 4'd5; bus_a.mem_rf_en = 1'b1;
    #2;
    n_vec++; if (bus_a.fwd_c !== 2'b10) begin $display("FAIL fwd_c_skip_load got %b exp 10", bus_a.fwd_c); n_miss++; end
    n_vec++; if (ctl_a !== 6'b100000) begin $display("FAIL lu_via_rd got %b exp 100000", ctl_a); n_miss++; end
    idle_cycles(3);
  endtask

  task automatic test_mem_wait();
    for (int i = 0; i < 3; i++) begin
      cyc();
      idle();
      bus_a.mem_access = 1'b1; bus_a.mem_ready = 1'b0;
      #2;
      n_vec++; if (ctl_a !== 6'b000010) begin $display("FAIL memwait_a[%0d] got %b exp 000010", i, ctl_a); n_miss++; end
      n_vec++; if (ctl_b !== 6'b000010) begin $display("FAIL memwait_b[%0d] got %b exp 000010", i, ctl_b); n_miss++; end
    end
    cyc();
    bus_a.mem_ready = 1'b1;
    #2;
    n_vec++; if (ctl_a !== 6'b011000) begin $display("FAIL memready_a got %b exp 011000", ctl_a); n_miss++; end
    n_vec++; if (ctl_b !== 6'b011000) begin $display("FAIL memready_b got %b exp 011000", ctl_b); n_miss++; end
    idle_cycles(1);
  endtask

  task automatic test_mem_timeout();
    for (int i = 0; i < 3; i++) begin
      cyc();
      idle();
      bus_a.mem_access = 1'b1; bus_a.mem_ready = 1'b0;
      #2;
      n_vec++; if (ctl_a !== 6'b000010) begin $display("FAIL tmo_wait_a[%0d] got %b exp 000010", i, ctl_a); n_miss++; end
    end
    cyc();
    #2;
    n_vec++; if (ctl_a !== 6'b011001) begin $display("FAIL tmo_fault_a got %b exp 011001", ctl_a); n_miss++; end
    n_vec++; if (ctl_b !== 6'b000010) begin $display("FAIL tmo_nofault_b got %b exp 000010", ctl_b); n_miss++; end
    cyc();
    #2;
    n_vec++; if (ctl_a !== 6'b000010) begin $display("FAIL tmo_rewait_a got %b exp 000010", ctl_a); n_miss++; end
    cyc();
    bus_a.mem_ready = 1'b1;
    #2;
    n_vec++; if (ctl_b !== 6'b011000) begin $display("FAIL tmo_ready_b got %b exp 011000", ctl_b); n_miss++; end
    idle_cycles(1);
  endtask

  task automatic test_branch_lu();
    cyc();
    idle();
    bus_a.ex_load = 1'b1; bus_a.ex_rf_en = 1'b1; bus_a.ex_rd = 4'd7;
    bus_a.id_rm = 4'd7; bus_a.id_use_rm = 1'b1; bus_a.ex_branch_taken = 1'b1;
    #2;
    n_vec++; if (ctl_a !== 6'b111100) begin $display("FAIL br_flush_a got %b exp 111100", ctl_a); n_miss++; end
    n_vec++; if (ctl_b !== 6'b111100) begin $display("FAIL br_flush_b got %b exp 111100", ctl_b); n_miss++; end
    cyc();
    idle();
    #2;
    n_vec++; if (ctl_b !== 6'b011000) begin $display("FAIL br_nostall_b got %b exp 011000", ctl_b); n_miss++; end
  endtask

  task automatic test_reset_mid_stall();
    cyc();
    idle();
    bus_a.ex_load = 1'b1; bus_a.ex_rf_en = 1'b1; bus_a.ex_rd = 4'd3;
    bus_a.id_rn = 4'd3; bus_a.id_use_rn = 1'b1;
    #2;
    n_vec++; if (ctl_b !== 6'b100000) begin $display("FAIL rst_pre_b got %b exp 100000", ctl_b); n_miss++; end
    cyc();
    idle();
    reset = 1'b1;
    #2;
    n_vec++; if (ctl_b !== 6'b011000) begin $display("FAIL rst_during_b got %b exp 011000", ctl_b); n_miss++; end
    cyc();
    reset = 1'b0;
    #2;
    n_vec++; if (ctl_b !== 6'b011000) begin $display("FAIL rst_after_b got %b exp 011000", ctl_b); n_miss++; end
`ifdef HAZARD_STATS_EN
    n_vec++; if (bus_b.stall_count !== 16'd0) begin $display("FAIL rst_stats_b got %0d exp 0", bus_b.stall_count); n_miss++; end
`endif
  endtask

  task automatic test_back_to_back();
    cyc();
    idle();
    bus_a.ex_load = 1'b1; bus_a.ex_rf_en = 1'b1; bus_a.ex_rd = 4'd3;
    bus_a.id_rn = 4'd3; bus_a.id_use_rn = 1'b1;
    #2;
    n_vec++; if (ctl_a !== 6'b100000) begin $display("FAIL b2b_first got %b exp 100000", ctl_a); n_miss++; end
    cyc();
    bus_a.ex_rd = 4'd4; bus_a.id_rm = 4'd4; bus_a.id_use_rm = 1'b1;
    bus_a.mem_rd = 4'd3; bus_a.mem_rf_en = 1'b1;
    #2;
    n_vec++; if (ctl_a !== 6'b100000) begin $display("FAIL b2b_second got %b exp 100000", ctl_a); n_miss++; end
    n_vec++; if (bus_a.fwd_a !== 2'b10) begin $display("FAIL b2b_fwd_a got %b exp 10", bus_a.fwd_a); n_miss++; end
    cyc();
    idle();
    #2;
    n_vec++; if (ctl_a !== 6'b011000) begin $display("FAIL b2b_release got %b exp 011000", ctl_a); n_miss++; end
    idle_cycles(3);
  endtask

`ifdef HAZARD_STATS_EN
  task automatic test_stats();
    cyc();
    reset = 1'b1;
    idle();
    cyc();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      bus_a.ex_branch_taken = 1'b1;
    end
    cyc();
    idle();
    #2;
    n_vec++; if (bus_a.stall_count !== 16'd2) begin $display("FAIL stats_count got %0d exp 2", bus_a.stall_count); n_miss++; end
  endtask
`endif

  initial begin
    n_vec  = 0;
    n_miss = 0;
    reset  = 1'b1;
    idle();
    test_reset();
    test_load_use();
    test_forwarding();
    test_mem_wait();
    test_mem_timeout();
    test_branch_lu();
    test_reset_mid_stall();
    test_back_to_back();
`ifdef HAZARD_STATS_EN
    test_stats();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the 5-stage ARM-subset core (IF/ID/EX/MEM/WB). It drives the select line of the ID-stage control-signal mux that inserts a NOP bubble. It also generates the PC and IF/ID latch enables, the IF/ID flush, the data-memory freeze and the EX-operand forwarding selects. Load-use stalls, data-memory wait states and taken-branch flushes are sequenced by a small FSM with a stall counter and a memory-wait timeout.

## Interface
Parameters:
- LU_STALL_CYCLES, 1, bubbles inserted per load-use hazard (1..7)
- MEM_TIMEOUT, 15, max consecutive MEM wait cycles before forced release (1..255)

Ports:
- clk  in  1  core clock; everything updates on rising edge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- id_rn, id_rm, id_rd  in  4 each  ID-stage source register numbers (rd = store data source)
- id_use_rn, id_use_rm, id_use_rd  in  1 each  corresponding source is actually read
- ex_rd  in  4  EX-stage destination; ex_rf_en  in  1; ex_load  in  1  EX instruction is a load
- mem_rd  in  4; mem_rf_en  in  1  MEM-stage destination/write enable
- wb_rd  in  4; wb_rf_en  in  1  WB-stage destination/write enable
- mem_access  in  1  MEM-stage datamem_en; mem_ready  in  1  data memory completes this cycle
- ex_branch_taken  in  1  EX resolved a taken branch/branch-link
- cu_sel  out  1  control-mux select; 1 = zero all ID control outputs (bubble)
- pc_le, ifid_le  out  1 each  PC / IF-ID latch enables
- ifid_flush  out  1  clear IF/ID to NOP on next edge
- pipe_hold  out  1  freeze ID/EX, EX/MEM, MEM/WB
- fwd_a, fwd_b, fwd_c  out  2 each  operand source for rn/rm/rd: 00 regfile, 01 EX, 10 MEM, 11 WB
- mem_fault  out  1  one-cycle pulse on MEM timeout

## Operation
- FSM states: RUN, LU_STALL, MEM_WAIT. Counter cnt (8 bits) shared.
- Load-use hit = ex_load & ex_rf_en & ex_rd != 15 & (id_use_x & id_x == ex_rd) for any x.
- Priority every cycle: reset > memory wait > branch flush > load-use.
- Memory wait (any state): mem_access & ~mem_ready -> pipe_hold=1, pc_le=0, ifid_le=0, cu_sel=0. State goes to MEM_WAIT and cnt increments. cnt == MEM_TIMEOUT-1 while still waiting -> mem_fault=1 for that cycle, hold released that cycle, next state RUN.
- MEM_WAIT -> RUN the cycle mem_ready=1 (hold deasserted that same cycle).
- Branch: ex_branch_taken & no memory wait -> ifid_flush=1, cu_sel=1 (kills ID instruction), pc_le=1. Pending LU_STALL is cancelled -> RUN.
- RUN + load-use hit -> cu_sel=1, pc_le=0, ifid_le=0 that cycle. If LU_STALL_CYCLES>1, go to LU_STALL with cnt=LU_STALL_CYCLES-1.
- LU_STALL: same outputs; cnt decrements; leave to RUN when cnt reaches 1.
- Forwarding (combinational, independent of FSM): per source, match EX (not load) > MEM > WB, requiring rf_en and rd != 15. Otherwise 00. The ID source use-flag must be set, else 00.
- Outputs with no hazard: cu_sel=0, pc_le=1, ifid_le=1, ifid_flush=0, pipe_hold=0, mem_fault=0.

## Timing
- Reset values (in and through the reset cycle): state RUN, cnt 0, cu_sel 0, pc_le 1, ifid_le 1, ifid_flush 0, pipe_hold 0, fwd_* 00, mem_fault 0, stall_count 0.
- Hazard outputs are combinational from inputs and registered state. Zero-cycle latency: the bubble is inserted in the detection cycle.
- Load-use costs exactly LU_STALL_CYCLES cycles. The instruction re-evaluates afterward; forwarding then selects MEM.
- Reset asserted mid-stall or mid-wait: next edge returns to RUN, and any in-progress count is discarded.
- Simultaneous branch + load-use: the flush wins and no stall is counted.

## Configuration
- HAZARD_STATS_EN defined: adds output stall_count (16 bits, saturating at 0xFFFF). It increments each cycle any of cu_sel or pipe_hold is 1, and is cleared by reset.
- Undefined: the port and counter are absent, and all other behaviour is identical.

## Structure
- Shared core package: the 2-bit forwarding-select encodings (FWD_RF/EX/MEM/WB), the PC register number constant (15) and the FSM state enum.
- One natural sub-module: hazard_fwd_sel, a per-operand forwarding priority selector instantiated three times.

## Test plan
- Load R1 in EX, ID reads rn=R1 (use set), LU_STALL_CYCLES=1 -> cu_sel=1, pc_le=0, ifid_le=0 for 1 cycle. Next cycle fwd_a=10.
- ADD writes R2 in EX, WB also writes R2, ID reads rm=R2 -> fwd_b=01 (EX beats WB). Same with rd=15 -> fwd_b=00.
- mem_access=1, mem_ready low 3 cycles -> pipe_hold=1 exactly 3 cycles, cu_sel=0, returns to RUN on the mem_ready cycle.
- mem_ready stuck low, MEM_TIMEOUT=4 -> mem_fault pulses on the 4th wait cycle, then pipe_hold=0.
- ex_branch_taken coincident with a load-use hit -> ifid_flush=1, cu_sel=1, pc_le=1, no stall next cycle.
- Reset asserted during LU_STALL with LU_STALL_CYCLES=3 -> all outputs at reset values next cycle. With HAZARD_STATS_EN, stall_count=0.
